// File: rtl/pipeline_id_queue_pkg.sv
// Shared definitions for the Scipio decode-stage queue.
// Holds the instruction-format and ALU-operation encodings, the RV32I opcode
// and funct3/funct7 constants, the decoded-record struct carried through the
// queue, and a helper that maps an OP/OP-IMM funct3 onto an ALU operation.
package pipeline_id_queue_pkg;

  localparam int ALU_OPCODE_WIDTH = 4;

  typedef enum logic [ALU_OPCODE_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    TYPE_R   = 3'd0,
    TYPE_I   = 3'd1,
    TYPE_S   = 3'd2,
    TYPE_B   = 3'd3,
    TYPE_U   = 3'd4,
    TYPE_J   = 3'd5,
    TYPE_INV = 3'd7
  } inst_type_e;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 values for OP / shift-immediate
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // OP / OP-IMM funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load / store funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Decoded record stored per queue entry (imm is kept separately because
  // its width follows XLEN).
  typedef struct packed {
    inst_type_e typ;
    alu_op_e    alu;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
  } dec_t;

  // Base (funct7 = 0000000) mapping of funct3 to ALU operation.
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SRL:  return ALU_SRL;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_id_queue_id_decoder.sv
// id_decoder: purely combinational RV32I instruction decoder.
// Ports:
//   inst_i  - raw 32-bit instruction word
//   dec_o   - decoded record (format, ALU op, register indices, illegal flag)
//   imm_o   - immediate sign-extended to XLEN (0 for R-type and illegal)
// An illegal encoding yields TYPE_INV, ALU_ADD, imm 0 and zeroed register
// indices so downstream logic sees a deterministic record.
module id_decoder
  import pipeline_id_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output dec_t            dec_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;

  assign opcode_s = inst_i[6:0];
  assign funct3_s = inst_i[14:12];
  assign funct7_s = inst_i[31:25];

  // 32-bit sign-extended immediates of every format; widened to XLEN below.
  assign imm_i_s = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b_s = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u_s = {inst_i[31:12], 12'h000};
  assign imm_j_s = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  logic        bad_s;
  dec_t        raw_s;
  logic [31:0] raw_imm_s;

  // Format/opcode decode before the illegal override.
  always_comb begin
    bad_s         = 1'b0;
    raw_s.typ     = TYPE_INV;
    raw_s.alu     = ALU_ADD;
    raw_s.rs1     = inst_i[19:15];
    raw_s.rs2     = inst_i[24:20];
    raw_s.rd      = inst_i[11:7];
    raw_s.illegal = 1'b0;
    raw_imm_s     = 32'h0000_0000;
    case (opcode_s)
      OPC_R_TYPE: begin
        raw_s.typ = TYPE_R;
        if (funct7_s == F7_BASE) begin
          raw_s.alu = f3_to_alu(funct3_s);
        end else if (funct7_s == F7_ALT && funct3_s == F3_ADD) begin
          raw_s.alu = ALU_SUB;
        end else if (funct7_s == F7_ALT && funct3_s == F3_SRL) begin
          raw_s.alu = ALU_SRA;
        end else begin
          bad_s = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        raw_s.typ = TYPE_I;
        raw_s.rs2 = 5'd0;
        raw_imm_s = imm_i_s;
        case (funct3_s)
          F3_SLL: begin
            if (funct7_s == F7_BASE) raw_s.alu = ALU_SLL;
            else                     bad_s = 1'b1;
          end
          F3_SRL: begin
            if (funct7_s == F7_BASE)     raw_s.alu = ALU_SRL;
            else if (funct7_s == F7_ALT) raw_s.alu = ALU_SRA;
            else                         bad_s = 1'b1;
          end
          default: raw_s.alu = f3_to_alu(funct3_s);
        endcase
      end
      OPC_LOAD: begin
        raw_s.typ = TYPE_I;
        raw_s.rs2 = 5'd0;
        raw_imm_s = imm_i_s;
        case (funct3_s)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: bad_s = 1'b0;
          default:                             bad_s = 1'b1;
        endcase
      end
      OPC_STORE: begin
        raw_s.typ = TYPE_S;
        raw_s.rd  = 5'd0;
        raw_imm_s = imm_s_s;
        case (funct3_s)
          F3_SB, F3_SH, F3_SW: bad_s = 1'b0;
          default:             bad_s = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        raw_s.typ = TYPE_B;
        raw_s.rd  = 5'd0;
        raw_imm_s = imm_b_s;
        case (funct3_s)
          F3_BEQ, F3_BNE:   raw_s.alu = ALU_SUB;
          F3_BLT, F3_BGE:   raw_s.alu = ALU_SLT;
          F3_BLTU, F3_BGEU: raw_s.alu = ALU_SLTU;
          default:          bad_s = 1'b1;
        endcase
      end
      OPC_JAL: begin
        raw_s.typ = TYPE_J;
        raw_s.rs2 = 5'd0;
        raw_imm_s = imm_j_s;
      end
      OPC_JALR: begin
        raw_s.typ = TYPE_I;
        raw_s.rs2 = 5'd0;
        raw_imm_s = imm_i_s;
      end
      OPC_LUI: begin
        raw_s.typ = TYPE_U;
        raw_s.rs1 = 5'd0;
        raw_s.rs2 = 5'd0;
        raw_imm_s = imm_u_s;
      end
      OPC_AUIPC: begin
        raw_s.typ = TYPE_U;
        raw_s.rs2 = 5'd0;
        raw_imm_s = imm_u_s;
      end
      default: bad_s = 1'b1;
    endcase
  end

  // Illegal override: compressed/garbage low bits or any bad field.
  always_comb begin
    if (bad_s || inst_i[1:0] != 2'b11) begin
      dec_o.typ     = TYPE_INV;
      dec_o.alu     = ALU_ADD;
      dec_o.rs1     = 5'd0;
      dec_o.rs2     = 5'd0;
      dec_o.rd      = 5'd0;
      dec_o.illegal = 1'b1;
      imm_o         = {XLEN{1'b0}};
    end else begin
      dec_o = raw_s;
      imm_o = XLEN'($signed(raw_imm_s));
    end
  end

endmodule

// File: rtl/pipeline_id_queue.sv
// pipeline_id_queue: decode stage with a DEPTH-entry in-order queue.
// Ports:
//   clk, rst (async, active-low), flush (sync, discards everything)
//   in_valid/in_ready/in_inst/in_pc    - IF side handshake
//   out_valid/out_ready/out_pc         - EX side handshake
//   decoded_type, alu_opcode, rs1, rs2, rd, imm, illegal - head record
//   occupancy                          - entries currently held
// Instructions are decoded on entry and the decoded record is stored. Head
// fields come straight from storage and read 0 whenever the queue is empty.
module pipeline_id_queue
  import pipeline_id_queue_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_inst,
  input  logic [PC_WIDTH-1:0]         in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PC_WIDTH-1:0]         out_pc,
  output logic [2:0]                  decoded_type,
  output logic [ALU_OPCODE_WIDTH-1:0] alu_opcode,
  output logic [4:0]                  rs1,
  output logic [4:0]                  rs2,
  output logic [4:0]                  rd,
  output logic [XLEN-1:0]             imm,
  output logic                        illegal,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  dec_t                  in_dec_s;
  logic [XLEN-1:0]       in_imm_s;

  id_decoder #(.XLEN(XLEN)) u_dec (
    .inst_i (in_inst),
    .dec_o  (in_dec_s),
    .imm_o  (in_imm_s)
  );

  dec_t                  dec_mem_q [DEPTH];
  logic [XLEN-1:0]       imm_mem_q [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem_q  [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic                  push_s;
  logic                  pop_s;

  // in_ready is held low during reset; no pass-through when full.
  assign in_ready  = rst && !flush && (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != {CNT_W{1'b0}});
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign occupancy = count_q;

  // Pointer and count next state; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      // DEPTH is a power of two, so natural overflow gives the wrap.
      if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observable through a valid head, so
  // it needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      dec_mem_q[wr_ptr_q] <= in_dec_s;
      imm_mem_q[wr_ptr_q] <= in_imm_s;
      pc_mem_q[wr_ptr_q]  <= in_pc;
    end
  end

  dec_t                  head_dec_s;
  logic [XLEN-1:0]       head_imm_s;
  logic [PC_WIDTH-1:0]   head_pc_s;

  // Head read, forced to zero when nothing is held (including reset).
  always_comb begin
    if (out_valid) begin
      head_dec_s = dec_mem_q[rd_ptr_q];
      head_imm_s = imm_mem_q[rd_ptr_q];
      head_pc_s  = pc_mem_q[rd_ptr_q];
    end else begin
      head_dec_s = '0;
      head_imm_s = {XLEN{1'b0}};
      head_pc_s  = {PC_WIDTH{1'b0}};
    end
  end

  assign out_pc       = head_pc_s;
  assign decoded_type = head_dec_s.typ;
  assign alu_opcode   = head_dec_s.alu;
  assign rs1          = head_dec_s.rs1;
  assign rs2          = head_dec_s.rs2;
  assign rd           = head_dec_s.rd;
  assign imm          = head_imm_s;
  assign illegal      = head_dec_s.illegal;

endmodule

// File: doc/pipeline_id_queue.md
Name: pipeline_id_queue

Overview:
Parametrised decode stage for the Scipio integer pipeline, successor to pipeline_id.
- Accepts fetched instructions over a valid/ready handshake.
- Fully decodes each one on entry: type, ALU opcode, register indices, sign-extended immediate, illegal flag.
- Holds decoded entries in a DEPTH-entry in-order queue between IF and EX, with flush support for branch redirect.

Parameters:
XLEN, 32, datapath width of imm; legal values 32 or 64.
PC_WIDTH, 32, width of the carried program counter.
DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-low.
flush  input  1  discard all queued entries.
in_valid  input  1  IF presents an instruction.
in_ready  output  1  queue can accept.
in_inst  input  32  raw RV32I instruction.
in_pc  input  PC_WIDTH  PC of in_inst.
out_valid  output  1  head entry valid.
out_ready  input  1  EX consumes head.
out_pc  output  PC_WIDTH  PC of head.
decoded_type  output  3  head instruction format.
alu_opcode  output  `ALU_OPCODE_WIDTH  head ALU operation.
rs1, rs2, rd  output  5 each  head register indices.
imm  output  XLEN  head sign-extended immediate.
illegal  output  1  head instruction is illegal.
occupancy  output  $clog2(DEPTH+1)  entries held.

Behaviour:
- Reset (rst low, asynchronous): pointers and count cleared. out_valid=0, occupancy=0, in_ready=0 while rst is asserted. All head fields read 0.
- Push on in_valid && in_ready. Pop on out_valid && out_ready. Both may occur in the same cycle.
- in_ready = (count < DEPTH) && !flush. When full there is no pass-through: a same-cycle pop does not enable a push.
- Latency: an entry pushed at edge N is visible at the head after edge N when the queue was empty. Outputs come straight from storage; there is no combinational path from in_* to out_*.
- Order is strict FIFO. Pointers wrap modulo DEPTH. Count updates +1, -1, or 0 for simultaneous push/pop.
- flush is synchronous and has priority. At the next edge count=0 and pointers are reset. Any push or pop in the flush cycle is discarded.
- Decode runs combinationally on in_inst. The decoded record is written, not the raw word.
- decoded_type: R, I, S, B, U, J, INV.
- R-type: funct7 0000000 maps by funct3 to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7 0100000 gives SUB (funct3 000) or SRA (funct3 101).
- OP-IMM: same mapping without SUB. Shifts require funct7 0000000, or 0100000 for SRAI.
- ALU_ADD is used for:
  - LOAD, STORE, JALR, AUIPC, JAL (address calculation);
  - LUI, with rs1 forced to 0.
- Branches: BEQ/BNE → ALU_SUB. BLT/BGE → ALU_SLT. BLTU/BGEU → ALU_SLTU.
- rs2 is forced to 0 for I, U and J types. rd is forced to 0 for S and B types.
- Illegal encodings, each of which sets illegal=1, decoded_type=INV, alu_opcode=ALU_ADD, imm=0 and is still queued:
  - in_inst[1:0] != 11;
  - unknown opcode;
  - bad funct7;
  - branch funct3 010 or 011;
  - load/store funct3 outside the legal set.
- imm: I/S/B/U/J formats per the RV32I spec, sign-extended to XLEN. B and J immediates have bit0 = 0.
- Reset mid-operation: all contents are lost immediately. out_valid drops asynchronously.

Decomposition:
- Shared define.h gets:
  - TYPE_R..TYPE_J and TYPE_INV encodings (0-5, 7);
  - opcode constants for LOAD, STORE, BRANCH, JAL, JALR, OP_IMM, LUI, AUIPC;
  - branch and load/store funct3 constants.
- Existing `ALU_*`, `POS_*` and `*_FUNCT3/7` definitions are reused as they are.
- One sub-module, id_decoder: a purely combinational inst → decoded record. pipeline_id_queue wraps it with the queue and handshake.

Test Plan:
- ADD: rst released, random inst with opcode R_TYPE_OPCODE, ADD_FUNCT3, ADD_FUNCT7, rs1=3, rs2=4, rd=5, pushed at edge N → after edge N: out_valid=1, alu_opcode=ALU_ADD, decoded_type=R, rs1=3, rs2=4, rd=5, illegal=0.
- ADDI x1,x0,-1 (0xFFF00093) → decoded_type=I, imm=0xFFFFFFFF, rd=1, rs1=0, rs2=0. BEQ x1,x2,-4 (0xFE208EE3) → type B, ALU_SUB, imm=0xFFFFFFFC.
- Fill and drain, DEPTH=4, out_ready=0: push PCs 0x0, 0x4, 0x8, 0xC → in_ready=0 and occupancy=4 after the 4th push; a 5th in_valid is not accepted. Then out_ready=1 → heads pop in order 0x0, 0x4, 0x8, 0xC, and in_ready rises after the first pop.
- Simultaneous push and pop at occupancy 2 → occupancy stays 2 and order is preserved. Repeat past pointer wrap, more than 8 transfers.
- Flush with occupancy 3 while in_valid=1 and out_ready=1 → next cycle occupancy=0, out_valid=0. The flush-cycle input is not queued and no pop is counted.
- Illegal 0x00000000 and an R-type with funct7 0100000, funct3 001 → illegal=1, decoded_type=INV, imm=0, each queued in order. rst pulsed low mid-queue → out_valid=0 immediately, occupancy=0.
